// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: sequencer for an LFSR shift register.
// Loads a seed on request, then steps the register a programmed number of cycles.
// The result is reported through a busy/done handshake. Stepping can be paused
// with hold, and a run can be cancelled with abort.
//
// Ports:
//   clock     - rising-edge clock
//   r         - asynchronous active-high reset
//   start     - load seed and run (sampled only while idle)
//   seed      - initial register value, captured on the accepted start
//   steps     - number of shifts to perform, captured with seed
//   hold      - freezes stepping while running
//   abort     - ends the run without a done pulse
//   q         - current LFSR register value
//   remaining - shifts still to perform
//   busy      - high while not idle
//   done      - one-cycle pulse when a run completes
module lfsr_run_ctrl #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter int unsigned     CNT_W = 8
) (
  input  logic             clock,
  input  logic             r,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] steps,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_next;

  // Left shift with XOR feedback of the tapped bits into bit 0.
  assign q_next = {q_q[WIDTH-2:0], ^(q_q & TAPS)};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          // An all-zero seed would lock the LFSR at zero forever.
          q_d     = (seed == '0) ? WIDTH'(1) : seed;
          rem_d   = steps;
          state_d = (steps != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!hold) begin
          q_d   = q_next;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge r) begin
    if (r) begin
      state_q <= StIdle;
      q_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
    end
  end

  // Outputs are pure decodes of registered state.
  assign q         = q_q;
  assign remaining = rem_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
module tb_lfsr_run_ctrl;

  logic       clock = 1'b0;
  logic       r     = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed  = '0;
  logic [7:0] steps = '0;
  logic       hold  = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] q;
  logic [7:0] remaining;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_run_ctrl #(
    .WIDTH(8),
    .TAPS (8'hB8),
    .CNT_W(8)
  ) dut (
    .clock    (clock),
    .r        (r),
    .start    (start),
    .seed     (seed),
    .steps    (steps),
    .hold     (hold),
    .abort    (abort),
    .q        (q),
    .remaining(remaining),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  // Reference model: a run is described by its effective seed, its shift
  // count and how many shifts have happened so far.
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  logic [7:0] m_seed = '0;
  int         m_n    = 0;
  int         m_k    = 0;

  function automatic logic [7:0] adv(input logic [7:0] v, input int n);
    logic [7:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = {x[6:0], ^(x & 8'hB8)};
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_seed = '0;
    m_n    = 0;
    m_k    = 0;
  endtask

  task automatic check_model();
    check("q", 32'(q), 32'(adv(m_seed, m_k)));
    check("remaining", 32'(remaining), 32'(m_n - m_k));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
  endtask

  // One clock edge: capture the inputs seen by the edge, advance the model,
  // then compare just after the edge.
  task automatic tick();
    logic       s_start, s_abort, s_hold;
    logic [7:0] s_seed, s_steps;
    s_start = start;
    s_abort = abort;
    s_hold  = hold;
    s_seed  = seed;
    s_steps = steps;
    @(posedge clock);
    #1;
    if (!m_busy) begin
      if (s_start && !s_abort) begin
        m_seed = (s_seed == 8'h00) ? 8'h01 : s_seed;
        m_n    = int'(s_steps);
        m_k    = 0;
        m_busy = 1'b1;
        m_done = (s_steps == 8'h00);
      end
    end else if (m_done) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (s_abort) begin
      m_busy = 1'b0;
    end else if (!s_hold) begin
      m_k++;
      if (m_k == m_n) m_done = 1'b1;
    end
    check_model();
  endtask

  task automatic launch(input logic [7:0] sd, input logic [7:0] st);
    seed  = sd;
    steps = st;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] seed;
    logic [7:0] steps;
    logic [7:0] exp_q;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  lat;
    bit  got;
    int  dup;
    int  zero;
    bit  seen[256];

    vecs[0] = '{8'h01, 8'd4,   8'h11, 5};
    vecs[1] = '{8'h00, 8'd1,   8'h02, 2};
    vecs[2] = '{8'h3C, 8'd0,   8'h3C, 1};
    vecs[3] = '{8'hA5, 8'd255, 8'hA5, 256};
    vecs[4] = '{8'h80, 8'd3,   8'h04, 4};
    vecs[5] = '{8'hFF, 8'd1,   8'hFE, 2};

    // Reset while idle at time 0.
    #2;
    check("rst_q", 32'(q), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    #10;
    r = 1'b0;
    tick();

    // Reset asserted mid-run takes effect without a clock edge.
    launch(8'h5A, 8'd20);
    for (int i = 0; i < 4; i++) tick();
    #2;
    r = 1'b1;
    #1;
    check("midrst_q", 32'(q), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_rem", 32'(remaining), 32'h0);
    model_reset();
    #2;
    r = 1'b0;
    tick();

    // Table-driven runs with constant expectations.
    foreach (vecs[v]) begin
      launch(vecs[v].seed, vecs[v].steps);
      lat  = 1;
      got  = done;
      dup  = 0;
      zero = 0;
      foreach (seen[i]) seen[i] = 1'b0;
      while (!got && lat < int'(vecs[v].steps) + 20) begin
        if (q == 8'h00) zero++;
        if (seen[q]) dup++;
        seen[q] = 1'b1;
        tick();
        lat++;
        got = done;
      end
      check("tbl_latency", 32'(lat), 32'(vecs[v].exp_lat));
      check("tbl_final_q", 32'(q), 32'(vecs[v].exp_q));
      check("tbl_rem_at_done", 32'(remaining), 32'h0);
      check("tbl_no_zero", 32'(zero), 32'h0);
      check("tbl_no_repeat", 32'(dup), 32'h0);
      tick();
      check("tbl_busy_after", 32'(busy), 32'h0);
      check("tbl_done_after", 32'(done), 32'h0);
    end

    // Hold for three cycles after the second shift.
    launch(8'h01, 8'd4);
    tick();
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q", 32'(q), 32'h04);
    end
    hold = 1'b0;
    tick();
    tick();
    check("hold_done", 32'(done), 32'h1);
    check("hold_final_q", 32'(q), 32'h11);
    tick();

    // Abort on the second RUN cycle.
    launch(8'h01, 8'd4);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_q", 32'(q), 32'h02);
    tick();
    tick();
    check("abort_no_done", 32'(done), 32'h0);

    // Abort and hold together: abort wins.
    launch(8'h01, 8'd4);
    abort = 1'b1;
    hold  = 1'b1;
    tick();
    abort = 1'b0;
    hold  = 1'b0;
    check("abort_hold_busy", 32'(busy), 32'h0);
    check("abort_hold_q", 32'(q), 32'h01);

    // Start together with abort in IDLE is not accepted.
    seed  = 8'h33;
    steps = 8'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'h0);

    // Start during RUN is ignored, then back-to-back runs.
    launch(8'h01, 8'd4);
    tick();
    seed  = 8'h77;
    steps = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ign_done", 32'(done), 32'h1);
    check("ign_q", 32'(q), 32'h11);
    seed  = 8'h01;
    steps = 8'd3;
    start = 1'b1;
    tick();
    check("b2b_idle", 32'(busy), 32'h0);
    tick();
    start = 1'b0;
    check("b2b_accept", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) tick();
    check("b2b_done", 32'(done), 32'h1);
    check("b2b_q", 32'(q), 32'h08);
    tick();

    // Randomized runs against the model.
    for (int run = 0; run < 40; run++) begin
      launch(8'($urandom), 8'($urandom_range(0, 20)));
      for (int c = 0; c < 200 && m_busy; c++) begin
        hold  = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 4) == 0) begin
          start = 1'b1;
          seed  = 8'($urandom);
          steps = 8'($urandom_range(0, 20));
        end
        tick();
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
      end
      check("rand_finished", 32'(busy), 32'h0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
